sub_div_seq: RTL and testbench
==============================

SUB_DIV_SEQ -- requirements
Module: sub_div_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand width; only 64 is supported, matching sub_64_bit.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division, sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, 64 bits: unsigned numerator, captured when start is accepted.
REQ-006 The block SHALL have port divisor, input, 64 bits: unsigned denominator, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse that marks valid results.
REQ-009 The block SHALL have port quotient, output, 64 bits: the registered result.
REQ-010 The block SHALL have port remainder, output, 64 bits: the registered result.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: registered flag, valid with done.

Function
REQ-012 The block SHALL instantiate exactly one sub_64_bit (ports a, b, S, C, where C=1 iff a>=b unsigned, i.e. no borrow) and SHALL perform every subtraction through it.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE transitions: start=1 with divisor!=0 goes to RUN, loads R=0, Q=dividend, D=divisor and cnt=0; start=1 with divisor==0 goes to DONE; otherwise IDLE is held.
REQ-015 Each RUN cycle SHALL perform one restoring step:
 - P = {R[62:0], Q[63]}, with shift-out bit h = R[63];
 - drive subtractor a=P, b=D;
 - qbit = h | C;
 - R <= qbit ? S : P;
 - Q <= {Q[62:0], qbit};
 - cnt <= cnt+1.
REQ-016 When h=1, S (modulo 2^64) SHALL be taken as the correct new remainder, because the true 65-bit P exceeds D.
REQ-017 RUN SHALL last exactly 64 cycles (cnt 0..63); the cycle with cnt==63 SHALL transition to DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-019 Latency: a start accepted at edge N SHALL give done=1 in the cycle after edge N+64 for a normal divide, and in the cycle after edge N for a zero divisor.
REQ-020 quotient, remainder and div_by_zero SHALL update only on the edge that enters DONE, and SHALL then hold until the next DONE.
REQ-021 Zero divisor SHALL produce quotient=64'hFFFF_FFFF_FFFF_FFFF, remainder=dividend and div_by_zero=1.
REQ-022 A normal divide SHALL produce quotient=Q, remainder=R and div_by_zero=0.
REQ-023 start, dividend and divisor SHALL be ignored while busy=1, with no queueing.
REQ-024 A start in the same cycle as the DONE->IDLE transition SHALL be ignored; a start is accepted only when the state is IDLE at the sampling edge.
REQ-025 dividend=0 SHALL complete through the full 64 RUN cycles with quotient=0 and remainder=0.
REQ-026 When the FSM is not in RUN, the subtractor inputs SHALL be driven from registered values only, with no combinational path from start, dividend or divisor to any output.

Reset
REQ-027 rst=1 at a clock edge SHALL, on that edge, force state=IDLE and clear to 0: busy, done, quotient, remainder, div_by_zero, R, Q, D and cnt.
REQ-028 Reset SHALL take priority over start and over any RUN or DONE activity.
REQ-029 A reset mid-RUN SHALL abort the division with no done pulse.
REQ-030 After rst deasserts, a start on the next edge SHALL be accepted normally.

Verification
REQ-031 dividend=78120, divisor=37821 -> done 65 cycles after start; quotient=2, remainder=2478, div_by_zero=0.
REQ-032 dividend=10024, divisor=12345 -> quotient=0, remainder=10024.
REQ-033 dividend=64'hFFFF_FFFF_FFFF_FFFF, divisor=64'h8000_0000_0000_0000 -> quotient=1, remainder=64'h7FFF_FFFF_FFFF_FFFF; this case exercises h=1.
REQ-034 dividend=12345, divisor=0 -> done one cycle after start; quotient=all ones, remainder=12345, div_by_zero=1.
REQ-035 Start 1000/7, then pulse start with 5/1 at RUN cycle 10 -> the second start is ignored; result quotient=142, remainder=6.
REQ-036 Start 1000/7, then assert rst at RUN cycle 30 -> the next cycle shows busy=0 and all outputs 0, and no done pulse occurs; a later start with 9/3 gives quotient=3, remainder=0.

Source files
------------

// File: rtl/sub_div_seq.sv
// sub_div_seq -- sequential unsigned 64-bit restoring divider.
//
// A start seen in IDLE captures the operands. The block then runs one
// restoring step per clock for 64 clocks and pulses done for one cycle with
// the registered quotient and remainder. A zero divisor skips the iteration:
// it goes straight to DONE with quotient = all ones, remainder = dividend and
// div_by_zero = 1. Every subtraction goes through one shared sub_64_bit.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start        division request, sampled only in IDLE
//   dividend     unsigned numerator, captured when start is accepted
//   divisor      unsigned denominator, captured when start is accepted
//   busy         high in RUN and DONE
//   done         one-cycle pulse, results valid
//   quotient     registered quotient, held until the next DONE
//   remainder    registered remainder, held until the next DONE
//   div_by_zero  registered flag, valid with done
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results from the last division are held
// RUN   | one restoring step per cycle, cnt counts 0..63
// DONE  | done pulse for one cycle, then back to IDLE unconditionally

module sub_div_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] r_reg, r_nxt;
    logic [WIDTH-1:0] q_reg, q_nxt;
    logic [WIDTH-1:0] d_reg, d_nxt;
    logic [5:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0] quo_nxt, rem_nxt;
    logic             dbz_nxt;

    logic [WIDTH-1:0] sub_a;
    logic [WIDTH-1:0] sub_s;
    logic             sub_c;
    logic             h;
    logic             qbit;

    // The subtractor is always fed from registers, so outside RUN its
    // inputs never depend on start/dividend/divisor.
    assign h     = r_reg[WIDTH-1];
    assign sub_a = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};

    sub_64_bit u_sub (
        .a (sub_a),
        .b (d_reg),
        .S (sub_s),
        .C (sub_c)
    );

    // With h set, the true 65-bit partial remainder exceeds D, so the step
    // must subtract; the wrapped 64-bit difference is then exact.
    assign qbit = h | sub_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nxt;
            r_reg       <= r_nxt;
            q_reg       <= q_nxt;
            d_reg       <= d_nxt;
            cnt         <= cnt_nxt;
            quotient    <= quo_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= dbz_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_nxt     = r_reg;
        q_nxt     = q_reg;
        d_nxt     = d_reg;
        cnt_nxt   = cnt;
        quo_nxt   = quotient;
        rem_nxt   = remainder;
        dbz_nxt   = div_by_zero;

        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_nxt = DONE;
                        quo_nxt   = '1;
                        rem_nxt   = dividend;
                        dbz_nxt   = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        r_nxt     = '0;
                        q_nxt     = dividend;
                        d_nxt     = divisor;
                        cnt_nxt   = '0;
                    end
                end
            end
            RUN: begin
                r_nxt   = qbit ? sub_s : sub_a;
                q_nxt   = {q_reg[WIDTH-2:0], qbit};
                cnt_nxt = cnt + 6'd1;
                if (cnt == 6'd63) begin
                    state_nxt = DONE;
                    quo_nxt   = q_nxt;
                    rem_nxt   = r_nxt;
                    dbz_nxt   = 1'b0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

endmodule

// sub_64_bit -- S = a - b (mod 2^64), C = 1 when a >= b (no borrow).
// Computed as a + ~b + 1 with 4-bit carry-lookahead groups whose group
// carries ripple from one group to the next.
//
// Ports
//   a  minuend
//   b  subtrahend
//   S  difference modulo 2^64
//   C  carry out, i.e. not-borrow
module sub_64_bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] S,
    output logic        C
);

    logic [63:0] g;
    logic [63:0] p;
    logic [16:0] gc;

    assign g     = a & ~b;
    assign p     = a ^ ~b;
    assign gc[0] = 1'b1;

    for (genvar k = 0; k < 16; k++) begin : g_grp
        logic [3:0] gg;
        logic [3:0] pp;
        logic [4:0] c;

        assign gg   = g[4*k +: 4];
        assign pp   = p[4*k +: 4];
        assign c[0] = gc[k];
        assign c[1] = gg[0] | (pp[0] & c[0]);
        assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
        assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                    | (pp[2] & pp[1] & pp[0] & c[0]);
        assign c[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                    | (pp[3] & pp[2] & pp[1] & gg[0])
                    | (pp[3] & pp[2] & pp[1] & pp[0] & c[0]);

        assign S[4*k +: 4] = pp ^ c[3:0];
        assign gc[k+1]     = c[4];
    end

    assign C = gc[16];

endmodule

// File: tb/tb_sub_div_seq.sv
// Bench for sub_div_seq: a cycle-level reference model built on plain
// integer / and %, compared against the DUT every cycle, plus directed
// vectors with hand-computed results and latencies.

module tb_sub_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    sub_div_seq #(.WIDTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_left counts cycles still to be spent busy.
    int          m_left = 0;
    logic [63:0] m_q = '0, m_r = '0;
    logic        m_dbz = 1'b0;
    logic [63:0] p_q = '0, p_r = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_q    = '0;
            m_r    = '0;
            m_dbz  = 1'b0;
        end else if (m_left == 0) begin
            if (start === 1'b1) begin
                if (divisor == 64'd0) begin
                    m_left = 1;
                    m_q    = '1;
                    m_r    = dividend;
                    m_dbz  = 1'b1;
                end else begin
                    m_left = 65;
                    p_q    = dividend / divisor;
                    p_r    = dividend % divisor;
                end
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_q   = p_q;
                m_r   = p_r;
                m_dbz = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (busy !== (m_left > 0) || done !== (m_left == 1) || quotient !== m_q ||
                remainder !== m_r || div_by_zero !== m_dbz) begin
                errors++;
                $display("FAIL cycle_model: got busy=%b done=%b q=%h r=%h dbz=%b required busy=%b done=%b q=%h r=%h dbz=%b at %0t",
                         busy, done, quotient, remainder, div_by_zero,
                         (m_left > 0), (m_left == 1), m_q, m_r, m_dbz, $time);
            end
        end
    end

    task automatic launch(input logic [63:0] dvd, input logic [63:0] dvs);
        @(negedge clk);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(negedge clk);
        start    = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
    endtask

    // Counts negedges until done; the first negedge after the start edge is 1.
    task automatic wait_done(input int from, output int lat, output bit got);
        lat = from;
        got = (done === 1'b1);
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            got = (done === 1'b1);
        end
    endtask

    task automatic run_div(input string name, input logic [63:0] dvd, input logic [63:0] dvs,
                           input logic [63:0] eq, input logic [63:0] er, input logic edbz,
                           input int elat);
        int lat;
        bit got;
        launch(dvd, dvs);
        wait_done(1, lat, got);
        check({name, "_done_seen"}, 64'(got), 64'd1);
        check({name, "_latency"}, 64'(lat), 64'(elat));
        check({name, "_quotient"}, quotient, eq);
        check({name, "_remainder"}, remainder, er);
        check({name, "_dbz"}, 64'(div_by_zero), 64'(edbz));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat;
        bit got;
        int ndone;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_quotient", quotient, 64'd0);
        check("reset_remainder", remainder, 64'd0);
        rst = 1'b0;

        run_div("basic", 64'd78120, 64'd37821, 64'd2, 64'd2478, 1'b0, 65);
        run_div("small_over_big", 64'd10024, 64'd12345, 64'd0, 64'd10024, 1'b0, 65);
        run_div("high_bit", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 65);
        run_div("div_zero", 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd12345, 1'b1, 1);
        run_div("zero_dividend", 64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 65);
        run_div("max_by_one", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65);
        run_div("equal", 64'd100, 64'd100, 64'd1, 64'd0, 1'b0, 65);
        run_div("max_by_3", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
                64'h5555_5555_5555_5555, 64'd0, 1'b0, 65);
        run_div("big_by_big", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65);

        // Second start during RUN cycle 10 must be ignored.
        launch(64'd1000, 64'd7);
        repeat (10) @(negedge clk);
        start    = 1'b1;
        dividend = 64'd5;
        divisor  = 64'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(12, lat, got);
        check("ignore_start_done", 64'(got), 64'd1);
        check("ignore_start_latency", 64'(lat), 64'd65);
        check("ignore_start_quotient", quotient, 64'd142);
        check("ignore_start_remainder", remainder, 64'd6);

        // Start held through the DONE->IDLE edge is accepted one edge later.
        launch(64'd50, 64'd8);
        wait_done(1, lat, got);
        check("b2b_first_done", 64'(got), 64'd1);
        start    = 1'b1;
        dividend = 64'd77;
        divisor  = 64'd10;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(2, lat, got);
        check("b2b_latency", 64'(lat), 64'd66);
        check("b2b_quotient", quotient, 64'd7);
        check("b2b_remainder", remainder, 64'd7);
        repeat (2) @(negedge clk);

        // Reset at RUN cycle 30 aborts with no done pulse.
        launch(64'd1000, 64'd7);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_quotient", quotient, 64'd0);
        check("abort_remainder", remainder, 64'd0);
        check("abort_dbz", 64'(div_by_zero), 64'd0);
        ndone = 0;
        repeat (70) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);

        // Reset released, then a start on the very next edge.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        start    = 1'b1;
        dividend = 64'd9;
        divisor  = 64'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat, got);
        check("after_reset_latency", 64'(lat), 64'd65);
        check("after_reset_quotient", quotient, 64'd3);
        check("after_reset_remainder", remainder, 64'd0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
